// File: rtl/fc_argmax_sink_if.sv
// Bus between the final fully-connected stage and the argmax sink.
// Write strobe is a one-cycle push with no backpressure; end_to_previous pulses once the buffer is free again.
interface fc_argmax_sink_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 4
);
  logic                  start_from_previous;
  logic [DATA_WIDTH-1:0] Data_in_1;
  logic [DATA_WIDTH-1:0] Data_in_2;
  logic [DATA_WIDTH-1:0] Data_in_3;
  logic [DATA_WIDTH-1:0] Data_in_4;
  logic [DATA_WIDTH-1:0] Data_in_5;
  logic [DATA_WIDTH-1:0] Data_in_6;
  logic [DATA_WIDTH-1:0] Data_in_7;
  logic [DATA_WIDTH-1:0] Data_in_8;
  logic [DATA_WIDTH-1:0] Data_in_9;
  logic [DATA_WIDTH-1:0] Data_in_10;
  logic                  end_to_previous;
  logic                  busy;
  logic                  output_ready;
  logic [INDEX_BITS-1:0] class_index;
  logic [DATA_WIDTH-1:0] class_score;
  logic                  overflow;
  logic [1:0]            dbg_state;

  modport master (
    output start_from_previous, Data_in_1, Data_in_2, Data_in_3, Data_in_4, Data_in_5,
           Data_in_6, Data_in_7, Data_in_8, Data_in_9, Data_in_10,
    input  end_to_previous, busy, output_ready, class_index, class_score, overflow, dbg_state
  );

  modport slave (
    input  start_from_previous, Data_in_1, Data_in_2, Data_in_3, Data_in_4, Data_in_5,
           Data_in_6, Data_in_7, Data_in_8, Data_in_9, Data_in_10,
    output end_to_previous, busy, output_ready, class_index, class_score, overflow, dbg_state
  );
endinterface

// File: rtl/fc_argmax_sink.sv
// Captures ten class scores in one cycle, scans them one per cycle for the
// strictly-greatest (lowest index on ties) and reports the winning class.
module fc_argmax_sink #(
  parameter int DATA_WIDTH        = 32,
  parameter int ARITH_TYPE        = 0,
  parameter int NUMBER_OF_CLASSES = 10,
  parameter int INDEX_BITS        = $clog2(NUMBER_OF_CLASSES)
) (
  input logic           clk,
  input logic           reset,
  fc_argmax_sink_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_capture;
  logic                  w_last;
  logic                  w_gt;
  logic [DATA_WIDTH-1:0] w_in [NUMBER_OF_CLASSES];
  logic [DATA_WIDTH-1:0] w_cand;
  logic [DATA_WIDTH-1:0] w_next_best;
  logic [INDEX_BITS-1:0] w_next_idx;

  logic [DATA_WIDTH-1:0] r_buf [NUMBER_OF_CLASSES];
  logic [DATA_WIDTH-1:0] r_best;
  logic [INDEX_BITS-1:0] r_best_idx;
  logic [INDEX_BITS-1:0] r_k;
  logic [INDEX_BITS-1:0] r_class_index;
  logic [DATA_WIDTH-1:0] r_class_score;
  logic                  r_overflow;

  // True when candidate a must replace best b. Float mode orders by sign and
  // magnitude, treats +0 == -0, and never lets a NaN candidate win.
  function automatic logic f_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic a_nan;
    if (ARITH_TYPE == 0) return $signed(a) > $signed(b);
    a_nan = (&a[30:23]) && (|a[22:0]);
    if (a_nan) return 1'b0;
    if ((a[DATA_WIDTH-2:0] == '0) && (b[DATA_WIDTH-2:0] == '0)) return 1'b0;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return b[DATA_WIDTH-1];
    if (a[DATA_WIDTH-1]) return a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
    return a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
  endfunction

  assign w_in[0] = bus.Data_in_1;
  assign w_in[1] = bus.Data_in_2;
  assign w_in[2] = bus.Data_in_3;
  assign w_in[3] = bus.Data_in_4;
  assign w_in[4] = bus.Data_in_5;
  assign w_in[5] = bus.Data_in_6;
  assign w_in[6] = bus.Data_in_7;
  assign w_in[7] = bus.Data_in_8;
  assign w_in[8] = bus.Data_in_9;
  assign w_in[9] = bus.Data_in_10;

  assign w_cand      = r_buf[r_k];
  assign w_gt        = f_gt(w_cand, r_best);
  assign w_next_best = w_gt ? w_cand : r_best;
  assign w_next_idx  = w_gt ? r_k : r_best_idx;
  assign w_last      = (r_k == INDEX_BITS'(NUMBER_OF_CLASSES - 1));

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_from_previous) begin
          w_capture    = 1'b1;
          w_next_state = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        // A strobe in the result cycle is accepted back-to-back.
        w_next_state = S_IDLE;
        if (bus.start_from_previous) begin
          w_capture    = 1'b1;
          w_next_state = S_SCAN;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUMBER_OF_CLASSES; i++) r_buf[i] <= '0;
      r_best        <= '0;
      r_best_idx    <= '0;
      r_k           <= '0;
      r_class_index <= '0;
      r_class_score <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_capture) begin
        for (int i = 0; i < NUMBER_OF_CLASSES; i++) r_buf[i] <= w_in[i];
        r_best     <= w_in[0];
        r_best_idx <= '0;
        r_k        <= INDEX_BITS'(1);
      end else if (r_state == S_SCAN) begin
        r_best     <= w_next_best;
        r_best_idx <= w_next_idx;
        r_k        <= r_k + INDEX_BITS'(1);
        // Result registers load with the final compare so they are valid in DONE.
        if (w_last) begin
          r_class_index <= w_next_idx;
          r_class_score <= w_next_best;
        end
      end
      if (bus.start_from_previous && (r_state == S_SCAN)) r_overflow <= 1'b1;
    end
  end

  assign bus.busy            = (r_state != S_IDLE);
  assign bus.output_ready    = (r_state == S_DONE);
  assign bus.end_to_previous = (r_state == S_DONE);
  assign bus.class_index     = r_class_index;
  assign bus.class_score     = r_class_score;
  assign bus.overflow        = r_overflow;
  assign bus.dbg_state       = r_state;

endmodule

// File: tb/tb_fc_argmax_sink.sv
// Drives identical score vectors into a signed and a float sink and checks
// each result against an argmax reference through per-instance expected queues.
module tb_fc_argmax_sink;
  localparam int DW = 32;
  localparam int IB = 4;
  localparam int NC = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fc_argmax_sink_if #(.DATA_WIDTH(DW), .INDEX_BITS(IB)) bus0 ();
  fc_argmax_sink_if #(.DATA_WIDTH(DW), .INDEX_BITS(IB)) bus1 ();

  fc_argmax_sink #(.DATA_WIDTH(DW), .ARITH_TYPE(0), .NUMBER_OF_CLASSES(NC), .INDEX_BITS(IB))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  fc_argmax_sink #(.DATA_WIDTH(DW), .ARITH_TYPE(1), .NUMBER_OF_CLASSES(NC), .INDEX_BITS(IB))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [DW-1:0]    vec [NC];
  logic [IB+DW-1:0] exp_q0[$];
  logic [IB+DW-1:0] exp_q1[$];
  int               cyc_q0[$];
  int               cyc_q1[$];
  int               last_accept = -1000;
  logic             exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Maps a float bit pattern onto a signed number line; both zeros land on 0.
  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic int ref_signed();
    int best = 0;
    for (int i = 1; i < NC; i++)
      if ($signed(vec[i]) > $signed(vec[best])) best = i;
    return best;
  endfunction

  function automatic int ref_float();
    int best = 0;
    for (int i = 1; i < NC; i++)
      if (!is_nan(vec[i]) && (fkey(vec[i]) > fkey(vec[best]))) best = i;
    return best;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_bus(input logic s);
    bus0.start_from_previous = s; bus1.start_from_previous = s;
    bus0.Data_in_1  = vec[0]; bus1.Data_in_1  = vec[0];
    bus0.Data_in_2  = vec[1]; bus1.Data_in_2  = vec[1];
    bus0.Data_in_3  = vec[2]; bus1.Data_in_3  = vec[2];
    bus0.Data_in_4  = vec[3]; bus1.Data_in_4  = vec[3];
    bus0.Data_in_5  = vec[4]; bus1.Data_in_5  = vec[4];
    bus0.Data_in_6  = vec[5]; bus1.Data_in_6  = vec[5];
    bus0.Data_in_7  = vec[6]; bus1.Data_in_7  = vec[6];
    bus0.Data_in_8  = vec[7]; bus1.Data_in_8  = vec[7];
    bus0.Data_in_9  = vec[8]; bus1.Data_in_9  = vec[8];
    bus0.Data_in_10 = vec[9]; bus1.Data_in_10 = vec[9];
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge; the strobe is sampled at the next rising edge.
  task automatic send();
    int e;
    int i0;
    int i1;
    e = cyc + 1;
    if (e - last_accept >= 10) begin
      i0 = ref_signed();
      i1 = ref_float();
      exp_q0.push_back({IB'(i0), vec[i0]});
      exp_q1.push_back({IB'(i1), vec[i1]});
      cyc_q0.push_back(cyc + 10);
      cyc_q1.push_back(cyc + 10);
      last_accept = e;
    end else begin
      exp_ovf = 1'b1;
    end
    set_bus(1'b1);
    @(negedge clk);
    for (int i = 0; i < NC; i++) vec[i] = $urandom;
    set_bus(1'b0);
  endtask

  task automatic load_ints(input int a0, input int a1, input int a2, input int a3, input int a4,
                           input int a5, input int a6, input int a7, input int a8, input int a9);
    vec[0] = a0; vec[1] = a1; vec[2] = a2; vec[3] = a3; vec[4] = a4;
    vec[5] = a5; vec[6] = a6; vec[7] = a7; vec[8] = a8; vec[9] = a9;
  endtask

  function automatic logic [31:0] rand_score();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 7)) - 32'd4;
      3: return {1'($urandom_range(0, 1)), 8'h7F, 23'($urandom_range(0, 15))};
      default: return $urandom;
    endcase
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_etp0"},  64'(bus0.end_to_previous), 64'd0);
    chk({tag, "_busy0"}, 64'(bus0.busy), 64'd0);
    chk({tag, "_rdy0"},  64'(bus0.output_ready), 64'd0);
    chk({tag, "_idx0"},  64'(bus0.class_index), 64'd0);
    chk({tag, "_scr0"},  64'(bus0.class_score), 64'd0);
    chk({tag, "_ovf0"},  64'(bus0.overflow), 64'd0);
    chk({tag, "_etp1"},  64'(bus1.end_to_previous), 64'd0);
    chk({tag, "_busy1"}, 64'(bus1.busy), 64'd0);
    chk({tag, "_rdy1"},  64'(bus1.output_ready), 64'd0);
    chk({tag, "_idx1"},  64'(bus1.class_index), 64'd0);
    chk({tag, "_scr1"},  64'(bus1.class_score), 64'd0);
    chk({tag, "_ovf1"},  64'(bus1.overflow), 64'd0);
  endtask

  // ---------------- monitor ----------------
  task automatic check_out(input int id, input logic [IB-1:0] idx, input logic [DW-1:0] sc,
                           input logic etp, input logic bsy);
    logic [IB+DW-1:0] e;
    int ec;
    if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL unexpected_result dut%0d actual_idx=%0d required=none t=%0t", id, idx, $time);
    end else begin
      if (id == 0) begin e = exp_q0.pop_front(); ec = cyc_q0.pop_front(); end
      else         begin e = exp_q1.pop_front(); ec = cyc_q1.pop_front(); end
      chk($sformatf("class_index%0d", id), 64'(idx), 64'(e[IB+DW-1:DW]));
      chk($sformatf("class_score%0d", id), 64'(sc), 64'(e[DW-1:0]));
      chk($sformatf("latency%0d", id), 64'(cyc), 64'(ec));
      chk($sformatf("end_to_prev%0d", id), 64'(etp), 64'd1);
      chk($sformatf("busy_done%0d", id), 64'(bsy), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    if (bus0.output_ready)
      check_out(0, bus0.class_index, bus0.class_score, bus0.end_to_previous, bus0.busy);
    if (bus1.output_ready)
      check_out(1, bus1.class_index, bus1.class_score, bus1.end_to_previous, bus1.busy);
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NC; i++) vec[i] = '0;
    set_bus(1'b0);
    reset = 1'b1;
    idle(3);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    idle(2);

    load_ints(5, -3, 12, 7, 0, 12, -100, 1, 2, 3);
    send(); idle(12);
    load_ints(-1, -1, -1, -1, -1, -1, -1, -1, -1, 32'h7FFF_FFFF);
    send(); idle(12);
    load_ints(32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h1234,
              32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h1234);
    send(); idle(12);
    load_ints(0, 32'h8000_0000, 0, 32'h4049_0FDB, 32'h8000_0000,
              0, 32'hC049_0FDB, 32'h8000_0000, 0, 32'h8000_0000);
    send(); idle(12);
    load_ints(32'h8000_0000, 0, 32'h8000_0000, 0, 0,
              32'h8000_0000, 0, 32'h8000_0000, 0, 32'h8000_0000);
    send(); idle(12);

    // Second strobe lands in the DONE cycle of the first.
    load_ints(1, 2, 3, 4, 5, 6, 7, 8, 9, 10);
    send(); idle(9);
    load_ints(10, 9, 8, 7, 6, 5, 4, 3, 2, 1);
    send(); idle(12);
    chk("ovf_b2b0", 64'(bus0.overflow), 64'(exp_ovf));
    chk("ovf_b2b1", 64'(bus1.overflow), 64'(exp_ovf));

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NC; i++) vec[i] = rand_score();
      send();
      idle(($urandom_range(0, 3) == 0) ? 9 : $urandom_range(10, 13));
    end
    idle(12);
    chk("ovf_rand0", 64'(bus0.overflow), 64'(exp_ovf));
    chk("ovf_rand1", 64'(bus1.overflow), 64'(exp_ovf));

    // Strobe four cycles into a scan is dropped.
    load_ints(3, 1, 4, 1, 5, 9, 2, 6, 5, 3);
    send(); idle(3);
    load_ints(100, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    send();
    chk("ovf_set0", 64'(bus0.overflow), 64'(exp_ovf));
    chk("ovf_set1", 64'(bus1.overflow), 64'(exp_ovf));
    idle(12);

    // Reset five cycles after a strobe aborts the scan silently.
    load_ints(7, 8, 9, 10, 11, 12, 13, 14, 15, 16);
    send(); idle(4);
    reset = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    cyc_q0.delete(); cyc_q1.delete();
    last_accept = -1000;
    exp_ovf = 1'b0;
    #1;
    check_idle_outputs("midrst");
    idle(2);
    reset = 1'b0;
    idle(15);
    load_ints(-5, -7, -2, -9, -2, -100, -3, -4, -8, -6);
    send(); idle(12);
    chk("ovf_after_rst0", 64'(bus0.overflow), 64'(exp_ovf));
    chk("ovf_after_rst1", 64'(bus1.overflow), 64'(exp_ovf));

    for (int i = 0; i < 100 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) @(negedge clk);
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending0=%0d pending1=%0d required=0", exp_q0.size(), exp_q1.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    total++;
    bad++;
    $display("FAIL watchdog expired at t=%0t required=completion", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fc_argmax_sink.md
# fc_argmax_sink

Downstream consumer for the final fully-connected stage of the LeNet5 unit. It sits at the far end of the `enable_write_next` / `end_from_next` handshake and latches the ten class scores in one cycle. It then scans them sequentially to find the winning class, reports the result, and returns `end_to_previous` so the FC stage may produce the next result.

## Interface
- `DATA_WIDTH`, 32, width of each class score.
- `ARITH_TYPE`, 0, score encoding: 0 = signed two's complement, 1 = IEEE-754 single precision (requires `DATA_WIDTH` = 32).
- `NUMBER_OF_CLASSES`, 10, fixed; must equal the number of `Data_in_*` ports.
- `INDEX_BITS`, `$clog2(NUMBER_OF_CLASSES)` = 4, width of the class index.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start_from_previous`  in  1  one-cycle write strobe from the FC stage's `enable_write_next`.
- `Data_in_1` … `Data_in_10`  in  `DATA_WIDTH` each  class scores (bias already included), valid in the strobe cycle.
- `end_to_previous`  out  1  one-cycle pulse: buffer free, drives the FC stage's `end_from_next`.
- `busy`  out  1  high while a captured vector is held/scanned.
- `output_ready`  out  1  one-cycle pulse: `class_index` / `class_score` updated.
- `class_index`  out  `INDEX_BITS`  winning class, 0-based (`Data_in_1` → 0).
- `class_score`  out  `DATA_WIDTH`  score of the winning class.
- `overflow`  out  1  sticky: a strobe arrived while busy; cleared only by reset.

## Operation
- FSM states: IDLE, SCAN, DONE.
- **IDLE**
  - On `start_from_previous`=1: capture all 10 inputs into a buffer. Initialise best = element 0, best_idx = 0, scan counter k = 1. Go to SCAN.
  - Otherwise stay in IDLE.
- **SCAN**
  - Each cycle compare buffer[k] with best. Replace best and best_idx only if buffer[k] is strictly greater, so ties keep the lower index.
  - k increments each cycle. When k = 9 has been compared, go to DONE.
- **DONE** (one cycle)
  - Register `class_index` = best_idx and `class_score` = best.
  - Pulse `output_ready` and `end_to_previous`.
  - Next state is IDLE, unless `start_from_previous`=1 in this cycle. In that case a new capture is performed exactly as in IDLE and the next state is SCAN (back-to-back accepted).
- **Strobe while busy:** a strobe in SCAN is ignored. The buffer is unchanged and `overflow` is set.
- `busy` = 1 in SCAN and DONE.
- **Compare, `ARITH_TYPE` 0:** signed compare over the full `DATA_WIDTH`.
- **Compare, `ARITH_TYPE` 1:** IEEE ordering.
  - Sign-magnitude compare; +0 and −0 are equal.
  - A NaN candidate never replaces best. A NaN in element 0 remains best only if no later element compares greater under raw-bit magnitude rules; no special NaN reporting.
- `class_index` and `class_score` hold their value between results.

## Timing
- Reset values: `end_to_previous` 0, `busy` 0, `output_ready` 0, `class_index` 0, `class_score` 0, `overflow` 0, FSM IDLE, buffer 0.
- Strobe sampled at edge t. SCAN occupies edges t+1 … t+9 (9 compares). DONE is the cycle after edge t+9.
- `output_ready` and `end_to_previous` are high for exactly one cycle, 10 cycles after the capture edge. `class_index` is valid in that same cycle.
- Minimum strobe spacing for loss-free operation is 10 cycles (strobe in DONE is accepted).
- Reset asserted mid-SCAN: immediate return to reset values. No `output_ready` or `end_to_previous` pulse for the aborted vector.
- Strobe coincident with reset deassertion edge: ignored.

## Test plan
- **Single vector, signed.** Scores 5, −3, 12, 7, 0, 12, −100, 1, 2, 3 (ARITH_TYPE 0) → `output_ready` pulse 10 cycles after the strobe with `class_index`=2 and `class_score`=12. The tie with index 5 resolves to the lower index. `end_to_previous` pulses in the same cycle.
- **Winner in last slot / all equal.**
  - All scores −1 except `Data_in_10`=0x7FFFFFFF → index 9.
  - All scores equal → index 0.
- **Float.** ARITH_TYPE 1 with `Data_in_4`=0x40490FDB (3.14159), `Data_in_7`=0xC0490FDB, others 0x00000000 / 0x80000000 → index 3. A separate vector of all ±0 → index 0.
- **Back-to-back and overflow.**
  - Second strobe in the DONE cycle → accepted; its result arrives 10 cycles later and `overflow` stays 0.
  - Strobe 4 cycles after a capture → ignored and `overflow`=1. The first result is unaffected.
- **Reset mid-scan.** Assert `reset` 5 cycles after a strobe → all outputs return to 0 immediately and no pulse follows. A new strobe after release produces the correct result.
